// File: rtl/vend_pkg.sv
// Shared vending constants: denominations, hopper bit positions and the
// one-hot state encoding of the change dispenser.
package vend_pkg;

  localparam int NUM_DENOM = 5;

  localparam int HOP_1  = 0;
  localparam int HOP_5  = 1;
  localparam int HOP_10 = 2;
  localparam int HOP_20 = 3;
  localparam int HOP_50 = 4;

  localparam logic [7:0] DENOM_1  = 8'd1;
  localparam logic [7:0] DENOM_5  = 8'd5;
  localparam logic [7:0] DENOM_10 = 8'd10;
  localparam logic [7:0] DENOM_20 = 8'd20;
  localparam logic [7:0] DENOM_50 = 8'd50;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    SELECT   = 4'b0010,
    DISPENSE = 4'b0100,
    WAIT_REL = 4'b1000
  } state_e;

  // Yuan value of the hopper at bit position idx.
  function automatic logic [7:0] denom_value(input int idx);
    case (idx)
      HOP_1:   return DENOM_1;
      HOP_5:   return DENOM_5;
      HOP_10:  return DENOM_10;
      HOP_20:  return DENOM_20;
      HOP_50:  return DENOM_50;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request / hopper bundle of the change dispenser; the controller takes the
// slave view, the vending logic and hopper take the master view.
interface change_dispenser_if;
  import vend_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [7:0]           req_amount;
  logic [NUM_DENOM-1:0] hop_empty;
  logic                 abort;
  logic [NUM_DENOM-1:0] disp_req;
  logic                 disp_ack;
  logic [7:0]           remaining;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 err_timeout;

  modport master (
    output req_valid, req_amount, hop_empty, abort, disp_ack,
    input  req_ready, disp_req, remaining, busy, done, error, err_timeout
  );

  modport slave (
    input  req_valid, req_amount, hop_empty, abort, disp_ack,
    output req_ready, disp_req, remaining, busy, done, error, err_timeout
  );

endinterface

// File: rtl/change_denom_sel.sv
// Greedy picker: largest non-empty denomination not exceeding the amount owed.
module change_denom_sel
  import vend_pkg::*;
(
  input  logic [7:0]           remaining_i,
  input  logic [NUM_DENOM-1:0] hop_empty_i,
  output logic [NUM_DENOM-1:0] pick_o,
  output logic [7:0]           value_o,
  output logic                 none_avail_o
);

  logic [NUM_DENOM-1:0]      usable;
  logic [NUM_DENOM:0][7:0]   value_acc;

  assign value_acc[0] = 8'd0;

  for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_pick
    assign usable[gi] = !hop_empty_i[gi] && (denom_value(gi) <= remaining_i);
    // A bit wins only when no larger denomination is usable.
    if (gi == NUM_DENOM - 1) begin : g_top
      assign pick_o[gi] = usable[gi];
    end else begin : g_low
      assign pick_o[gi] = usable[gi] && !(|usable[NUM_DENOM-1:gi+1]);
    end
    assign value_acc[gi+1] = value_acc[gi] | (pick_o[gi] ? denom_value(gi) : 8'd0);
  end

  assign value_o      = value_acc[NUM_DENOM];
  assign none_avail_o = ~|usable;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller: pays an amount out one coin/note at a time.
// Define DISPENSE_TIMEOUT_EN to abandon a payout when the hopper never acks.
module change_dispenser
  import vend_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  change_dispenser_if.slave  bus
);

  state_e               state_q;
  logic [7:0]           remaining_q;
  logic [7:0]           remaining_d;
  logic [7:0]           denom_q;
  logic [NUM_DENOM-1:0] disp_req_q;
  logic                 done_q;
  logic                 error_q;

  logic [NUM_DENOM-1:0] pick;
  logic [7:0]           pick_value;
  logic                 none_avail;

  change_denom_sel u_sel (
    .remaining_i  (remaining_q),
    .hop_empty_i  (bus.hop_empty),
    .pick_o       (pick),
    .value_o      (pick_value),
    .none_avail_o (none_avail)
  );

  // Cannot underflow: denom_q was chosen no larger than remaining_q.
  assign remaining_d = remaining_q - denom_q;

`ifdef DISPENSE_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;
  logic        err_timeout_q;

  assign tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      denom_q     <= '0;
      disp_req_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
      // Abort outranks a simultaneous ack, so the owed amount is untouched.
      if (bus.abort && state_q != IDLE) begin
        state_q    <= IDLE;
        disp_req_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.req_valid) begin
              remaining_q <= bus.req_amount;
              state_q     <= SELECT;
            end
          end
          SELECT: begin
            if (remaining_q == 8'd0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (none_avail) begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              disp_req_q <= pick;
              denom_q    <= pick_value;
              state_q    <= DISPENSE;
`ifdef DISPENSE_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end
          end
          DISPENSE: begin
            if (bus.disp_ack) begin
              remaining_q <= remaining_d;
              disp_req_q  <= '0;
              state_q     <= WAIT_REL;
`ifdef DISPENSE_TIMEOUT_EN
            end else if (tmo_cnt_d >= TIMEOUT_CYCLES) begin
              disp_req_q    <= '0;
              err_timeout_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_d;
`endif
            end
          end
          WAIT_REL: begin
            // Wait for the ack to drop so one ack level is counted once.
            if (!bus.disp_ack) begin
              state_q <= SELECT;
            end
          end
          default: begin
            state_q    <= IDLE;
            disp_req_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.disp_req  = disp_req_q;
  assign bus.remaining = remaining_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

`ifdef DISPENSE_TIMEOUT_EN
  assign bus.err_timeout = err_timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg  = ^TIMEOUT_CYCLES;
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: transaction-level greedy model
// plus directed scenarios (timeout scenario only with DISPENSE_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(.TIMEOUT_CYCLES(16'd8)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Hopper model: immediate ack of any request, or manual ack level.
  logic ack_imm_mode = 1'b1;
  logic ack_imm_r    = 1'b0;
  logic man_ack      = 1'b0;
  assign bus.disp_ack = ack_imm_mode ? ack_imm_r : man_ack;

  initial begin : hopper
    forever begin
      @(posedge clk);
      #1 ack_imm_r = |bus.disp_req;
    end
  end

  // Transaction model state.
  int         vals [5] = '{1, 5, 10, 20, 50};
  logic [4:0] exp_q [$];
  int         model_rem = 0;
  logic       exp_done = 1'b0;
  logic       model_on = 1'b0;
  int         done_cnt = 0;
  int         error_cnt = 0;
  int         tmo_cnt = 0;
  int         units_seen = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic int val_of(input logic [4:0] oh);
    int v = 0;
    for (int i = 0; i < 5; i++) if (oh[i]) v = vals[i];
    return v;
  endfunction

  // Greedy payout list from the amount and the empty hoppers.
  task automatic model_load(input int amt, input logic [4:0] hop, input logic use_it);
    int rem;
    int best;
    exp_q.delete();
    rem = amt;
    while (rem > 0) begin
      best = -1;
      for (int i = 0; i < 5; i++) if (!hop[i] && vals[i] <= rem) best = i;
      if (best < 0) break;
      exp_q.push_back(5'(1 << best));
      rem -= vals[best];
    end
    model_rem = amt;
    exp_done  = (rem == 0);
    model_on  = use_it;
  endtask

  initial begin : monitor
    logic [4:0] prev;
    logic [4:0] e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("disp_req_onehot0", int'($onehot0(bus.disp_req)), 1);
        check("busy_vs_ready", int'(bus.busy ^ bus.req_ready), 1);
        check("pulse_exclusive", int'($countones({bus.done, bus.error, bus.err_timeout}) <= 1), 1);
        if (bus.done) done_cnt++;
        if (bus.error) error_cnt++;
        if (bus.err_timeout) tmo_cnt++;
        if (bus.disp_req != 0 && prev == 0) begin
          units_seen++;
          if (model_on) begin
            if (exp_q.size() == 0) begin
              check("unit_unexpected", int'(bus.disp_req), 0);
            end else begin
              e = exp_q.pop_front();
              check("unit_denom", int'(bus.disp_req), int'(e));
              check("unit_remaining", int'(bus.remaining), model_rem);
              model_rem -= val_of(e);
            end
          end
        end
        if (model_on && (bus.done || bus.error)) begin
          check("outcome_done", int'(bus.done), int'(exp_done));
          check("final_remaining", int'(bus.remaining), model_rem);
          check("units_left", exp_q.size(), 0);
          model_on = 1'b0;
        end
        prev = bus.disp_req;
      end else begin
        prev = '0;
      end
    end
  end

  task automatic clear_counts();
    done_cnt = 0; error_cnt = 0; tmo_cnt = 0; units_seen = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(bus.req_ready), 1);
  endtask

  // Returns on the negedge after the handshake edge.
  task automatic do_req(input int amt, input logic [4:0] hop);
    @(negedge clk);
    wait_idle();
    bus.req_amount = 8'(amt);
    bus.hop_empty  = hop;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int kind, output int cyc);
    kind = 0;
    cyc  = 0;
    while (kind == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.done) kind = 1;
      else if (bus.error) kind = 2;
      else if (bus.err_timeout) kind = 3;
    end
  endtask

  task automatic wait_disp(input int budget);
    int n = 0;
    while (bus.disp_req == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("disp_req_seen", int'(bus.disp_req != 0), 1);
  endtask

  logic [4:0] lit78 [6] = '{5'b10000, 5'b01000, 5'b00010, 5'b00001, 5'b00001, 5'b00001};

  initial begin : stim
    int kind;
    int cyc;
    int hi;
    bus.req_valid = 1'b0; bus.req_amount = '0; bus.hop_empty = '0; bus.abort = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_disp_req", int'(bus.disp_req), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pulses", int'({bus.done, bus.error, bus.err_timeout}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 1);
    $display("reset: remaining=%0d req_ready=%0d", bus.remaining, bus.req_ready);

    model_load(78, 5'b00000, 1'b0);
    check("pin78_len", exp_q.size(), 6);
    for (int i = 0; i < 6; i++) check("pin78_item", int'(exp_q[i]), int'(lit78[i]));
    model_load(40, 5'b01000, 1'b0);
    check("pin40_len", exp_q.size(), 4);
    for (int i = 0; i < 4; i++) check("pin40_item", int'(exp_q[i]), 4);
    model_load(3, 5'b00001, 1'b0);
    check("pin3_len", exp_q.size(), 0);
    check("pin3_done", int'(exp_done), 0);

    // 78 yuan, all hoppers full: 50,20,5,1,1,1.
    clear_counts(); ack_imm_mode = 1'b1;
    model_load(78, 5'b00000, 1'b1);
    do_req(78, 5'b00000);
    check("lat_select", int'(bus.disp_req), 0);
    @(negedge clk);
    check("lat_first_unit", int'(bus.disp_req), 5'b10000);
    wait_end(200, kind, cyc);
    check("t78_kind", kind, 1);
    check("t78_remaining", int'(bus.remaining), 0);
    repeat (2) @(negedge clk);
    check("t78_done_pulses", done_cnt, 1);
    check("t78_units", units_seen, 6);
    $display("req 78: kind=%0d units=%0d remaining=%0d", kind, units_seen, bus.remaining);

    // 40 yuan, 20-yuan hopper empty: four 10s.
    clear_counts();
    model_load(40, 5'b01000, 1'b1);
    do_req(40, 5'b01000);
    wait_end(200, kind, cyc);
    check("t40_kind", kind, 1);
    repeat (2) @(negedge clk);
    check("t40_units", units_seen, 4);
    check("t40_done_pulses", done_cnt, 1);
    $display("req 40: kind=%0d units=%0d remaining=%0d", kind, units_seen, bus.remaining);

    // 3 yuan, 1-yuan hopper empty: shortfall.
    clear_counts();
    model_load(3, 5'b00001, 1'b1);
    do_req(3, 5'b00001);
    wait_end(20, kind, cyc);
    check("t3_kind", kind, 2);
    check("t3_latency", cyc, 1);
    check("t3_remaining", int'(bus.remaining), 3);
    repeat (3) @(negedge clk);
    check("t3_remaining_held", int'(bus.remaining), 3);
    check("t3_error_pulses", error_cnt, 1);
    check("t3_units", units_seen, 0);
    $display("req 3: kind=%0d remaining=%0d", kind, bus.remaining);

    // 0 yuan: done without any eject.
    clear_counts();
    model_load(0, 5'b00000, 1'b1);
    do_req(0, 5'b00000);
    wait_end(20, kind, cyc);
    check("t0_kind", kind, 1);
    check("t0_latency", cyc, 1);
    repeat (2) @(negedge clk);
    check("t0_units", units_seen, 0);
    check("t0_done_pulses", done_cnt, 1);
    $display("req 0: kind=%0d latency=%0d", kind, cyc);

    // hop_empty changing mid-dispense must not disturb the unit in flight.
    clear_counts(); ack_imm_mode = 1'b0; man_ack = 1'b0;
    model_load(25, 5'b00000, 1'b1);
    do_req(25, 5'b00000);
    wait_disp(10);
    check("hop_chg_first", int'(bus.disp_req), 5'b01000);
    bus.hop_empty = 5'b01100;
    @(negedge clk);
    check("hop_chg_held", int'(bus.disp_req), 5'b01000);
    ack_imm_mode = 1'b1;
    wait_end(100, kind, cyc);
    check("hop_chg_kind", kind, 1);
    check("hop_chg_units", units_seen, 2);
    bus.hop_empty = 5'b00000;
    $display("req 25 hop change: kind=%0d units=%0d", kind, units_seen);

    // Abort with simultaneous ack; request while busy is dropped.
    clear_counts(); ack_imm_mode = 1'b0; man_ack = 1'b0;
    do_req(78, 5'b00000);
    wait_disp(10);
`ifndef DISPENSE_TIMEOUT_EN
    repeat (20) @(negedge clk);
    check("no_tmo_still_req", int'(bus.disp_req), 5'b10000);
`endif
    bus.req_amount = 8'd9; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_req_ignored", int'(bus.remaining), 78);
    bus.abort = 1'b1; man_ack = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; man_ack = 1'b0;
    check("abort_disp_req", int'(bus.disp_req), 0);
    check("abort_remaining", int'(bus.remaining), 78);
    check("abort_ready", int'(bus.req_ready), 1);
    @(negedge clk);
    check("abort_no_pulse", done_cnt + error_cnt + tmo_cnt, 0);
    $display("abort: remaining=%0d req_ready=%0d", bus.remaining, bus.req_ready);

`ifdef DISPENSE_TIMEOUT_EN
    // No ack at all: give up after 8 DISPENSE cycles.
    clear_counts(); ack_imm_mode = 1'b0; man_ack = 1'b0;
    do_req(50, 5'b00000);
    hi = 0; kind = 0;
    for (int n = 0; n < 40 && kind == 0; n++) begin
      @(negedge clk);
      if (bus.disp_req != 0) hi++;
      if (bus.err_timeout) kind = 3;
    end
    check("tmo_seen", kind, 3);
    check("tmo_req_cycles", hi, 8);
    check("tmo_disp_req", int'(bus.disp_req), 0);
    check("tmo_remaining", int'(bus.remaining), 50);
    check("tmo_ready", int'(bus.req_ready), 1);
    $display("timeout: req_cycles=%0d remaining=%0d", hi, bus.remaining);
`endif

    // Reset while the 50-yuan request is out.
    clear_counts(); ack_imm_mode = 1'b0; man_ack = 1'b0;
    do_req(60, 5'b00000);
    wait_disp(10);
    check("rmid_pre", int'(bus.disp_req), 5'b10000);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_disp_req", int'(bus.disp_req), 0);
    check("rmid_remaining", int'(bus.remaining), 0);
    check("rmid_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmid_ready", int'(bus.req_ready), 1);
    check("rmid_disp_after", int'(bus.disp_req), 0);
    $display("reset mid-dispense: disp_req=%0d remaining=%0d", bus.disp_req, bus.remaining);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have one parameter line: TIMEOUT_CYCLES, default 16'd1000, number of cycles to wait for disp_ack before a timeout.
REQ-002 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  change request valid.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_amount  input  8  change to pay out, in yuan, range 0..255.
REQ-007 hop_empty  input  5  hopper-empty flags: bit0=1, bit1=5, bit2=10, bit3=20, bit4=50 yuan.
REQ-008 abort  input  1  synchronous abort of the current payout.
REQ-009 disp_req  output  5  one-hot coin/note eject request, with the same bit mapping as hop_empty.
REQ-010 disp_ack  input  1  hopper acknowledge: one unit ejected.
REQ-011 remaining  output  8  amount still owed.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the payout completes.
REQ-014 error  output  1  one-cycle pulse on shortfall: no usable denomination is left.
REQ-015 err_timeout  output  1  one-cycle pulse when the hopper ack times out; tied 0 when the timeout feature is compiled out.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, SELECT, DISPENSE, WAIT_REL.
- The FSM SHALL be one-hot encoded.
REQ-017 IDLE SHALL move to SELECT when req_valid && req_ready; in that same edge, remaining SHALL load req_amount.
REQ-018 SELECT SHALL pick the largest denomination d with d <= remaining and hop_empty[d]==0, then latch d and go to DISPENSE.
REQ-019 In SELECT with remaining==0, the block SHALL go to IDLE and pulse done in the next cycle.
REQ-020 In SELECT with remaining>0 and no usable d, the block SHALL go to IDLE, pulse error, and hold remaining at the unpaid value until the next request.
REQ-021 In DISPENSE, exactly one disp_req bit SHALL be high, held until disp_ack==1.
- On that ack, remaining SHALL drop by d, disp_req SHALL clear on the next edge, and the FSM SHALL go to WAIT_REL.
REQ-022 WAIT_REL SHALL hold disp_req=0 until disp_ack==0, then go to SELECT.
- One ack level SHALL never count twice.
REQ-023 Latency: for a handshake at edge N, disp_req SHALL be high from cycle N+2.
- The FSM SHALL spend one SELECT cycle between units.
REQ-024 The subtraction remaining-d SHALL be 8-bit and never underflow, because SELECT guarantees d<=remaining.
REQ-025 abort in any non-IDLE state SHALL force IDLE on the next edge, clear disp_req, and pulse neither done nor error.
- abort SHALL have priority over disp_ack in the same cycle, so remaining is unchanged.
REQ-026 A hop_empty change during DISPENSE SHALL NOT affect the request already in flight; it SHALL be sampled only in SELECT.
REQ-027 req_valid SHALL be ignored while busy, and any request presented then SHALL be lost.
REQ-028 done, error and err_timeout SHALL be mutually exclusive and registered.

Reset
REQ-029 On sys_rst_n low, the block SHALL immediately enter IDLE.
- Outputs: remaining=0, disp_req=0, done=0, error=0, err_timeout=0, busy=0, and req_ready=1 after release.
REQ-030 Reset mid-dispense SHALL drop disp_req within the reset assertion; the owed amount SHALL be lost.

Configuration
REQ-031 The macro DISPENSE_TIMEOUT_EN SHALL control the ack timeout.
- Defined: a 16-bit counter SHALL clear on entry to DISPENSE and increment each DISPENSE cycle.
- Defined: when the counter reaches TIMEOUT_CYCLES without ack, the block SHALL clear disp_req, go to IDLE, pulse err_timeout, and hold remaining.
- Undefined: there SHALL be no counter, DISPENSE SHALL wait indefinitely, and err_timeout SHALL be constant 0.

Structure
REQ-032 The shared package vend_pkg SHALL hold the following:
- denomination constants (1, 5, 10, 20, 50);
- the hopper bit indices;
- the state encoding constants.
REQ-033 The greedy picker SHALL be a combinational sub-module change_denom_sel.
- Inputs: remaining, hop_empty.
- Outputs: the one-hot pick, the value d, and a none_avail flag.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- req_amount=78, no hoppers empty, immediate acks -> disp_req order 50,20,5,1,1,1; remaining ends 0; done one pulse.
- req_amount=40, hop_empty[3]=1 -> four 10-yuan dispenses; done.
- req_amount=3, hop_empty[0]=1 -> no disp_req; error pulse; remaining=3.
- req_amount=0 -> done two cycles after the handshake; disp_req never high.
- DISPENSE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, disp_ack held 0 -> err_timeout after 8 DISPENSE cycles; disp_req cleared.
- Reset low while disp_req=5'b10000 -> disp_req=0 asynchronously; remaining=0; req_ready=1 after release.
